alu_operand_loader: RTL

//  Upstream stage of the 8-bit ALU: collects an opcode byte, operand A and operand B from a byte stream.

---
 rtl/alu_operand_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: collects opcode/A/B bytes from a byte stream and issues them to the ALU with valid/ready
// Ports: clk, rst (async active-high); in_data/in_valid/in_ready byte stream in;
//        op/A/B/opnd_valid/opnd_ready operand handshake out; err_timeout/err_parity 1-cycle error pulses;
//        op_count issued-operation counter.
// Optional feature: define PARITY_CHECK_EN to require a 4th check byte equal to opbyte^A^B.
module alu_operand_loader #(
  parameter int OP_WIDTH = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OP_WIDTH-1:0] op,
  output logic [7:0]          A,
  output logic [7:0]          B,
  output logic                opnd_valid,
  input  logic                opnd_ready,
  output logic                err_timeout,
  output logic                err_parity,
  output logic [15:0]         op_count
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
`ifdef PARITY_CHECK_EN
  localparam int SW = 8;
  typedef enum logic [2:0] {S_OP, S_A, S_B, S_CHK, S_ISSUE} state_t;
`else
  localparam int SW = OP_WIDTH;
  typedef enum logic [2:0] {S_OP, S_A, S_B, S_ISSUE} state_t;
`endif
  state_t r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_sop;
  logic [7:0] r_sa;
  logic [OP_WIDTH-1:0] r_op;
  logic [7:0] r_a, r_b;
  logic [15:0] r_count;
  logic r_err_to, r_err_par;
  logic w_acc, w_wait, w_to, w_load, w_par_bad;
  logic [7:0] w_b;
  assign in_ready = r_state != S_ISSUE;
  assign w_acc = in_valid && in_ready;
`ifdef PARITY_CHECK_EN
  logic [7:0] r_sb;
  assign w_wait = r_state inside {S_A, S_B, S_CHK};
  assign w_par_bad = r_state == S_CHK && w_acc && in_data != (r_sop ^ r_sa ^ r_sb);
  assign w_load = r_state == S_CHK && w_acc && !w_par_bad;
  assign w_b = r_sb;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sb <= '0;
    else if (w_acc && r_state == S_B) r_sb <= in_data;
`else
  assign w_wait = r_state inside {S_A, S_B};
  assign w_par_bad = 1'b0;
  assign w_load = r_state == S_B && w_acc;
  assign w_b = in_data;
`endif
  // Only an idle cycle can time out: a byte arriving as the timer hits the limit wins.
  assign w_to = TIMEOUT != 0 && w_wait && !w_acc && r_timer == TW'(TIMEOUT);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_OP;
    else r_state <= w_next;
  // Collection states are encoded consecutively, so an accepted byte advances by one.
  always_comb begin
    w_next = r_state;
    if (w_to || w_par_bad) w_next = S_OP;
    else if (w_load) w_next = S_ISSUE;
    else if (r_state == S_ISSUE) w_next = opnd_ready ? S_OP : S_ISSUE;
    else if (w_acc) w_next = state_t'(r_state + 3'd1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_timer <= '0;
    else if (w_acc || !w_wait || w_to) r_timer <= '0;
    else if (TIMEOUT != 0) r_timer <= r_timer + 1'b1;
  // Bytes land in shadow registers; op/A/B only change when a complete packet is issued,
  // so dropped packets leave the outputs untouched.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sop <= '0;
      r_sa <= '0;
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_count <= '0;
      r_err_to <= 1'b0;
      r_err_par <= 1'b0;
    end else begin
      if (w_acc && r_state == S_OP) r_sop <= in_data[SW-1:0];
      if (w_acc && r_state == S_A) r_sa <= in_data;
      if (w_load) begin
        r_op <= r_sop[OP_WIDTH-1:0];
        r_a <= r_sa;
        r_b <= w_b;
      end
      if (r_state == S_ISSUE && opnd_ready) r_count <= r_count + 16'd1;
      r_err_to <= w_to;
      r_err_par <= w_par_bad;
    end
  assign op = r_op;
  assign A = r_a;
  assign B = r_b;
  assign opnd_valid = r_state == S_ISSUE;
  assign err_timeout = r_err_to;
  assign err_parity = r_err_par;
  assign op_count = r_count;
endmodule
